keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 active-low matrix keypad, synchronises and debounces the row
//   inputs, and presents one stable key code plus a level "pressed" flag.
//   Sits directly upstream of the hero-selection and menu logic, which consume
//   key/keypad_pressed on the same clk and act on press level (their own edge latch).
// PARAMETERS
//   SCAN_DIV        50000  clk cycles each column is driven low (1 ms @ 50 MHz); >=4
//   DEBOUNCE_SWEEPS 10     consecutive identical full sweeps needed to commit; >=1
// PORTS
//   clk             in   1  system clock
//   rst             in   1  asynchronous reset, active-high
//   row             in   4  keypad rows, active-low (external pull-ups), asynchronous
//   col             out  4  keypad column drive, active-low, exactly one low at a time
//   keypad_pressed  out  1  high while a debounced key is held
//   key             out  5  debounced key code (valid while keypad_pressed)
// BEHAVIOUR
//   Reset (async, rst=1): col=4'b1110, keypad_pressed=0, key=NO_KEY(5'd31),
//     all counters/sync flops/sweep registers cleared, sweep result = NO_KEY.
//   Sync: row passes through a 2-flop synchroniser before any use.
//   Column scan: dwell counter counts 0..SCAN_DIV-1 per column; on terminal count
//     col rotates C0->C1->C2->C3->C0 (1110,1101,1011,0111). Synchronised rows are
//     sampled on the terminal-count cycle (settle time = SCAN_DIV-1 cycles).
//   Key map (row,col) -> code: R0: 1 2 3 A | R1: 4 5 6 B | R2: 7 8 9 C | R3: * 0 # D
//     digits = value, A=10 B=11 C=12 D=13 *=14 #=15, none = NO_KEY=31.
//   Sweep: accumulates over C0..C3; first low row found wins, priority lowest
//     column then lowest row (multi-key press yields exactly one code). At end of
//     the C3 dwell the sweep code is final and the accumulator resets to NO_KEY.
//   Debounce FSM (evaluated once per completed sweep):
//     IDLE   : committed NO_KEY. sweep != NO_KEY -> load cand, cnt=1, go CONFIRM
//              (if DEBOUNCE_SWEEPS==1 commit immediately, go HELD).
//     CONFIRM: sweep==cand -> cnt++; cnt reaching DEBOUNCE_SWEEPS commits cand:
//              key<=cand, keypad_pressed<=1, go HELD. sweep!=cand -> cand=sweep,
//              cnt=1 (NO_KEY sweep -> IDLE, outputs unchanged).
//     HELD   : sweep==key -> stay. Otherwise debounce the new value the same way
//              (RELEASE sub-count); after DEBOUNCE_SWEEPS identical sweeps:
//              NO_KEY -> keypad_pressed<=0, key keeps last code, go IDLE;
//              other code -> key<=new code, keypad_pressed stays 1 (no gap).
//   Outputs are registered; change only on the cycle after a sweep completes.
//   Latency press->keypad_pressed: DEBOUNCE_SWEEPS..DEBOUNCE_SWEEPS+1 sweeps
//     (sweep = 4*SCAN_DIV cycles) + 2 sync cycles; release symmetric.
//   Glitch shorter than one sweep within a stable run resets cnt; never commits.
//   Reset mid-scan or mid-debounce: immediate return to reset values, no output pulse.
// STRUCTURE
//   Shared include keypad_defs.vh: key code localparams (KEY_0..KEY_9, KEY_A..KEY_D,
//     KEY_STAR, KEY_HASH, NO_KEY=5'd31) and game-state codes, used by menu logic.
//   Sub-module keypad_debounce: sweep-code in + sweep_done strobe -> key/pressed,
//     holds the debounce FSM; scanner top holds sync, dwell counter, column ring,
//     (row,col)->code table.
// TESTING (bench with SCAN_DIV=4, DEBOUNCE_SWEEPS=3; keypad model shorts row<->col)
//   Reset: assert rst mid-cycle -> col=1110, keypad_pressed=0, key=31 same cycle.
//   Press '4' (R1,C0) held 10 sweeps -> keypad_pressed=1, key=4 within 4 sweeps+2;
//     release -> keypad_pressed=0 within 4 sweeps+2, key stays 4.
//   Press '6' and 'B' together -> key=6 (lower column wins); col always one-hot-low.
//   Roll '4'->'6' without release gap -> key 4 then 6, keypad_pressed never drops.
//   Bounce: '5' toggling every 1 sweep for 6 sweeps then steady -> no commit
//     during bounce, key=5 exactly 3 sweeps after bouncing stops (+1 sweep max).
//   Reset during CONFIRM (2 of 3 sweeps seen) -> after release of rst, a new full
//     3-sweep run is required before keypad_pressed rises.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - key codes, debounce state encodings and the (row,col) key map
package keypad_scanner_pkg;

   localparam logic [4:0] KEY_0    = 5'd0;
   localparam logic [4:0] KEY_1    = 5'd1;
   localparam logic [4:0] KEY_2    = 5'd2;
   localparam logic [4:0] KEY_3    = 5'd3;
   localparam logic [4:0] KEY_4    = 5'd4;
   localparam logic [4:0] KEY_5    = 5'd5;
   localparam logic [4:0] KEY_6    = 5'd6;
   localparam logic [4:0] KEY_7    = 5'd7;
   localparam logic [4:0] KEY_8    = 5'd8;
   localparam logic [4:0] KEY_9    = 5'd9;
   localparam logic [4:0] KEY_A    = 5'd10;
   localparam logic [4:0] KEY_B    = 5'd11;
   localparam logic [4:0] KEY_C    = 5'd12;
   localparam logic [4:0] KEY_D    = 5'd13;
   localparam logic [4:0] KEY_STAR = 5'd14;
   localparam logic [4:0] KEY_HASH = 5'd15;
   localparam logic [4:0] NO_KEY   = 5'd31;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONFIRM = 2'd1;
   localparam logic [1:0] ST_HELD    = 2'd2;

   function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [4:0] code;
      case ({r, c})
         4'b00_00: code = KEY_1;
         4'b00_01: code = KEY_2;
         4'b00_10: code = KEY_3;
         4'b00_11: code = KEY_A;
         4'b01_00: code = KEY_4;
         4'b01_01: code = KEY_5;
         4'b01_10: code = KEY_6;
         4'b01_11: code = KEY_B;
         4'b10_00: code = KEY_7;
         4'b10_01: code = KEY_8;
         4'b10_10: code = KEY_9;
         4'b10_11: code = KEY_C;
         4'b11_00: code = KEY_STAR;
         4'b11_01: code = KEY_0;
         4'b11_10: code = KEY_HASH;
         default:  code = KEY_D;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// rtl/keypad_scanner_debounce.sv - per-sweep debounce FSM turning sweep codes into key/pressed
module keypad_scanner_debounce
   import keypad_scanner_pkg::*;
#(
   parameter int DEBOUNCE_SWEEPS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sweep_done,
   input  logic [4:0] sweep_code,
   output logic [4:0] key,
   output logic       pressed
);

   localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);

   logic [1:0]    state;
   logic [4:0]    cand;
   logic [CW-1:0] cnt;
   logic [CW-1:0] next_cnt;
   logic          commit;

   // cnt==0 means no candidate run is in progress
   always_comb begin
      next_cnt = CW'(1);
      if (sweep_code == cand && cnt != '0)
         next_cnt = cnt + CW'(1);
      commit = (next_cnt == CW'(DEBOUNCE_SWEEPS));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cand    <= NO_KEY;
         cnt     <= '0;
         key     <= NO_KEY;
         pressed <= 1'b0;
      end else if (sweep_done) begin
         case (state)
            ST_IDLE, ST_CONFIRM: begin
               if (sweep_code == NO_KEY) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cand <= sweep_code;
                  if (commit) begin
                     key     <= sweep_code;
                     pressed <= 1'b1;
                     state   <= ST_HELD;
                     cnt     <= '0;
                  end else begin
                     cnt   <= next_cnt;
                     state <= ST_CONFIRM;
                  end
               end
            end
            ST_HELD: begin
               if (sweep_code == key) begin
                  cnt <= '0;
               end else begin
                  cand <= sweep_code;
                  if (commit) begin
                     cnt <= '0;
                     // release keeps the last code on key; a roll replaces it with no gap
                     if (sweep_code == NO_KEY) begin
                        pressed <= 1'b0;
                        state   <= ST_IDLE;
                     end else begin
                        key <= sweep_code;
                     end
                  end else begin
                     cnt <= next_cnt;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with row sync, sweep accumulation and debounce
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_SWEEPS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       keypad_pressed,
   output logic [4:0] key
);

   localparam int DW = $clog2(SCAN_DIV);

   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic [DW-1:0] dwell;
   logic [1:0]    col_idx;
   logic [4:0]    sweep_acc;
   logic [1:0]    row_idx;
   logic [4:0]    cur_code;
   logic [4:0]    sweep_code;
   logic          tc;
   logic          sweep_done;

   assign tc         = (dwell == DW'(SCAN_DIV - 1));
   assign sweep_done = tc && (col_idx == 2'd3);

   // descending loop so the lowest low row wins
   always_comb begin
      row_idx = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (!row_sync[i])
            row_idx = 2'(i);
      cur_code   = (row_sync != 4'hF) ? key_code(row_idx, col_idx) : NO_KEY;
      sweep_code = (sweep_acc != NO_KEY) ? sweep_acc : cur_code;
   end

   // sync flops clear to the idle (all-high) row level so reset never looks like a press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta  <= 4'hF;
         row_sync  <= 4'hF;
         dwell     <= '0;
         col_idx   <= 2'd0;
         col       <= 4'b1110;
         sweep_acc <= NO_KEY;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
         if (tc) begin
            dwell     <= '0;
            col_idx   <= col_idx + 2'd1;
            col       <= {col[2:0], col[3]};
            sweep_acc <= sweep_done ? NO_KEY : sweep_code;
         end else begin
            dwell <= dwell + DW'(1);
         end
      end
   end

   keypad_scanner_debounce #(
      .DEBOUNCE_SWEEPS(DEBOUNCE_SWEEPS)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .sweep_done (sweep_done),
      .sweep_code (sweep_code),
      .key        (key),
      .pressed    (keypad_pressed)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a row<->col shorting keypad model
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        keypad_pressed;
   logic [4:0]  key;
   logic [15:0] held = 16'h0;

   int n_cmp = 0;
   int n_bad = 0;
   int col_bad = 0;
   int drops = 0;
   int bounce_hits = 0;
   bit roll_watch = 1'b0;
   bit bounce_watch = 1'b0;
   int cyc;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV        (4),
      .DEBOUNCE_SWEEPS (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .row            (row),
      .col            (col),
      .keypad_pressed (keypad_pressed),
      .key            (key)
   );

   // held bit index = row*4 + col
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         if ((held[r*4 +: 4] & ~col) != 4'h0)
            row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (!(col inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) col_bad++;
      if (roll_watch && keypad_pressed !== 1'b1) drops++;
      if (bounce_watch && keypad_pressed !== 1'b0) bounce_hits++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      n_cmp++;
      assert (obs >= lo && obs <= hi) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_pressed(input logic val, output int c);
      c = 0;
      while (keypad_pressed !== val && c < 200) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic sweeps(input int n);
      repeat (16 * n) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_col", col, 4'b1110);
      check("rst_pressed", keypad_pressed, 1'b0);
      check("rst_key", key, 5'd31);
      rst = 1'b0;
      sweeps(2);
      check("idle_pressed", keypad_pressed, 1'b0);
      check("idle_key", key, 5'd31);

      // single press of '4' held ~10 sweeps, then release
      held[4] = 1'b1;
      wait_pressed(1'b1, cyc);
      check_range("press4_latency", cyc, 44, 66);
      check("press4_key", key, 5'd4);
      sweeps(6);
      check("hold4_pressed", keypad_pressed, 1'b1);
      check("hold4_key", key, 5'd4);
      held = 16'h0;
      wait_pressed(1'b0, cyc);
      check_range("release4_latency", cyc, 44, 66);
      check("release4_key_kept", key, 5'd4);

      // '6' and 'B' together: lower column wins
      held[6] = 1'b1;
      held[7] = 1'b1;
      wait_pressed(1'b1, cyc);
      check_range("dual_latency", cyc, 44, 66);
      check("dual_key", key, 5'd6);
      held = 16'h0;
      wait_pressed(1'b0, cyc);
      check_range("dual_release_latency", cyc, 44, 66);

      // roll '4' -> '6' with no release gap
      held[4] = 1'b1;
      wait_pressed(1'b1, cyc);
      check("roll_first_key", key, 5'd4);
      sweeps(2);
      roll_watch = 1'b1;
      held[4] = 1'b0;
      held[6] = 1'b1;
      cyc = 0;
      while (key !== 5'd6 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check_range("roll_latency", cyc, 30, 66);
      check("roll_second_key", key, 5'd6);
      sweeps(2);
      roll_watch = 1'b0;
      check("roll_no_drop", drops, 0);
      held = 16'h0;
      wait_pressed(1'b0, cyc);

      // '5' bouncing one sweep on / one off for 6 sweeps, then steady
      bounce_watch = 1'b1;
      for (int i = 0; i < 6; i++) begin
         held[5] = (i % 2 == 0);
         sweeps(1);
      end
      held[5] = 1'b1;
      bounce_watch = 1'b0;
      check("bounce_no_commit", bounce_hits, 0);
      check("bounce_key_hold", key, 5'd6);
      wait_pressed(1'b1, cyc);
      check_range("bounce_settle_latency", cyc, 44, 66);
      check("bounce_key", key, 5'd5);
      held = 16'h0;
      wait_pressed(1'b0, cyc);

      // press aligned to start of C0 so exactly 2 sweeps are seen before reset hits
      cyc = 0;
      while (col !== 4'b0111 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      while (col !== 4'b1110 && cyc < 80) begin
         @(negedge clk);
         cyc++;
      end
      check_range("align_c0", cyc, 1, 79);
      held[4] = 1'b1;
      repeat (40) @(negedge clk);
      check("confirm_not_yet", keypad_pressed, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("midrst_col", col, 4'b1110);
      check("midrst_pressed", keypad_pressed, 1'b0);
      check("midrst_key", key, 5'd31);
      @(negedge clk);
      rst = 1'b0;
      wait_pressed(1'b1, cyc);
      check_range("post_rst_full_run", cyc, 44, 66);
      check("post_rst_key", key, 5'd4);
      held = 16'h0;
      wait_pressed(1'b0, cyc);

      check("col_one_hot_low", col_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
